// File: rtl/pci_arbiter.sv
`default_nettype none
// ============================================================================
// pci_arbiter : round-robin PCI bus arbiter; grant moves only while bus is idle.
// Optional grant timeout compiled in when PCI_ARB_TIMEOUT_EN is defined.
// Revision : 1.0
// ============================================================================
module pci_arbiter #(
   parameter int N_DEV   = 4,
   parameter int TIMEOUT = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_DEV-1:0] request,
   input  logic             iframe,
   input  logic             iready,
   output logic [N_DEV-1:0] grant,
   output logic [2:0]       owner,
   output logic             bus_busy,
   output logic             timeout
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_BUSY  = 2'd2,
      ST_TURN  = 2'd3
   } state_t;

   localparam logic [2:0] LAST_OWNER_RST = 3'(N_DEV - 1);

   state_t           state_q, state_d;
   logic [N_DEV-1:0] grant_q, grant_d;
   logic [2:0]       owner_q, owner_d;
   logic [2:0]       last_owner_q, last_owner_d;
   logic             bus_busy_q, bus_busy_d;
   logic             timeout_q, timeout_d;

   logic [7:0]       req_ext;
   logic [3:0]       cand;
   logic [2:0]       winner;
   logic             any_req;

`ifdef PCI_ARB_TIMEOUT_EN
   localparam int          TW         = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
   logic [TW-1:0]          timer_q, timer_d;
`endif

   // Search downward so the candidate nearest to last_owner+1 is assigned last and wins.
   always_comb begin
      req_ext            = '1;
      req_ext[N_DEV-1:0] = request;
      any_req            = 1'b0;
      winner             = '0;
      cand               = '0;
      for (int i = N_DEV; i >= 1; i--) begin
         cand = {1'b0, last_owner_q} + 4'(i);
         if (cand >= 4'(N_DEV)) begin
            cand = cand - 4'(N_DEV);
         end
         if (!req_ext[cand[2:0]]) begin
            any_req = 1'b1;
            winner  = cand[2:0];
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      owner_d      = owner_q;
      last_owner_d = last_owner_q;
      timeout_d    = 1'b0;
`ifdef PCI_ARB_TIMEOUT_EN
      timer_d      = timer_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (any_req) begin
               for (int j = 0; j < N_DEV; j++) begin
                  grant_d[j] = (3'(j) != winner);
               end
               owner_d      = winner;
               last_owner_d = winner;
               state_d      = ST_GRANT;
`ifdef PCI_ARB_TIMEOUT_EN
               timer_d      = '0;
`endif
            end
         end
         ST_GRANT: begin
            if (!iframe) begin
               state_d = ST_BUSY;
            end else if (req_ext[owner_q]) begin
               grant_d = '1;
               state_d = ST_IDLE;
            end
`ifdef PCI_ARB_TIMEOUT_EN
            else if (timer_q == TIMER_LAST) begin
               grant_d   = '1;
               timeout_d = 1'b1;
               state_d   = ST_IDLE;
            end else begin
               timer_d = timer_q + TW'(1);
            end
`endif
         end
         ST_BUSY: begin
            if (iframe && iready) begin
               grant_d = '1;
               state_d = ST_TURN;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      bus_busy_d = (state_d == ST_BUSY);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         grant_q      <= '1;
         owner_q      <= '0;
         last_owner_q <= LAST_OWNER_RST;
         bus_busy_q   <= 1'b0;
         timeout_q    <= 1'b0;
`ifdef PCI_ARB_TIMEOUT_EN
         timer_q      <= '0;
`endif
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         owner_q      <= owner_d;
         last_owner_q <= last_owner_d;
         bus_busy_q   <= bus_busy_d;
         timeout_q    <= timeout_d;
`ifdef PCI_ARB_TIMEOUT_EN
         timer_q      <= timer_d;
`endif
      end
   end

   assign grant    = grant_q;
   assign owner    = owner_q;
   assign bus_busy = bus_busy_q;
   assign timeout  = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_pci_arbiter.sv
`default_nettype none
// ============================================================================
// tb_pci_arbiter : directed scoreboard bench for pci_arbiter (N_DEV=4, TIMEOUT=16).
// Revision : 1.0
// ============================================================================
module tb_pci_arbiter;

   logic       clk     = 1'b0;
   logic       rst     = 1'b1;
   logic [3:0] request = 4'hF;
   logic       iframe  = 1'b1;
   logic       iready  = 1'b1;
   logic [3:0] grant;
   logic [2:0] owner;
   logic       bus_busy;
   logic       timeout;

   pci_arbiter #(
      .N_DEV   (4),
      .TIMEOUT (16)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .request  (request),
      .iframe   (iframe),
      .iready   (iready),
      .grant    (grant),
      .owner    (owner),
      .bus_busy (bus_busy),
      .timeout  (timeout)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int         cyc;
      logic [3:0] g;
      logic [2:0] o;
      logic       bb;
      logic       to;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Expected output change dc edges after the inputs driven now.
   task automatic push_exp(input int dc, input logic [3:0] g, input logic [2:0] o,
                           input logic bb, input logic to);
      exp_t e;
      e.cyc = cyc + dc;
      e.g   = g;
      e.o   = o;
      e.bb  = bb;
      e.to  = to;
      q.push_back(e);
   endtask

   function automatic logic [3:0] gmask(input int d);
      logic [3:0] m;
      m    = 4'hF;
      m[d] = 1'b0;
      return m;
   endfunction

   task automatic chk_reset(input string name);
      checks++;
      if (grant !== 4'hF || owner !== 3'd0 || bus_busy !== 1'b0 || timeout !== 1'b0) begin
         errors++;
         $display("FAIL %s grant=%b owner=%0d busy=%b timeout=%b required grant=1111 owner=0 busy=0 timeout=0",
                  name, grant, owner, bus_busy, timeout);
      end
   endtask

   // Granted device runs a 3-cycle transaction; next grant follows after TURN + IDLE.
   task automatic txn(input int dev, input logic [3:0] ng, input int no);
      iframe = 1'b0;
      push_exp(1, gmask(dev), 3'(dev), 1'b1, 1'b0);
      repeat (3) step();
      iframe = 1'b1;
      push_exp(1, 4'hF, 3'(dev), 1'b0, 1'b0);
      push_exp(3, ng, 3'(no), 1'b0, 1'b0);
      repeat (3) step();
   endtask

   logic [8:0] prev;
   logic [8:0] cur;
   exp_t       mon_e;
   always @(negedge clk) begin
      cur = {grant, owner, bus_busy, timeout};
      if (rst) begin
         prev = cur;
      end else if (cur !== prev) begin
         prev = cur;
         checks++;
         if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_change cyc=%0d grant=%b owner=%0d busy=%b timeout=%b required no change",
                     cyc, grant, owner, bus_busy, timeout);
         end else begin
            mon_e = q.pop_front();
            if (cyc !== mon_e.cyc || grant !== mon_e.g || owner !== mon_e.o ||
                bus_busy !== mon_e.bb || timeout !== mon_e.to) begin
               errors++;
               $display("FAIL output_event cyc=%0d grant=%b owner=%0d busy=%b timeout=%b required cyc=%0d grant=%b owner=%0d busy=%b timeout=%b",
                        cyc, grant, owner, bus_busy, timeout,
                        mon_e.cyc, mon_e.g, mon_e.o, mon_e.bb, mon_e.to);
            end
         end
      end
   end

   initial begin
      repeat (3) step();
      chk_reset("reset_state");
      rst = 1'b0;
      step();

      // First grant goes to device 0
      request = 4'b1110;
      push_exp(1, 4'b1110, 3'd0, 1'b0, 1'b0);
      step();

      // All requesting: rotation 0,1,2,3,0,1
      request = 4'b0000;
      txn(0, 4'b1101, 1);
      txn(1, 4'b1011, 2);
      txn(2, 4'b0111, 3);
      txn(3, 4'b1110, 0);
      txn(0, 4'b1101, 1);

      // Device 1 withdraws in GRANT; device 2 takes over
      request = 4'b1011;
      push_exp(1, 4'hF, 3'd1, 1'b0, 1'b0);
      push_exp(2, 4'b1011, 3'd2, 1'b0, 1'b0);
      repeat (2) step();

      // Device 1 requests while device 2 is busy; iready holds the bus
      iframe = 1'b0;
      push_exp(1, 4'b1011, 3'd2, 1'b1, 1'b0);
      step();
      request = 4'b1001;
      repeat (2) step();
      iframe = 1'b1;
      iready = 1'b0;
      repeat (3) step();
      iready = 1'b1;
      push_exp(1, 4'hF, 3'd2, 1'b0, 1'b0);
      push_exp(3, 4'b1101, 3'd1, 1'b0, 1'b0);
      repeat (3) step();

      // Withdraw on the same edge iframe falls: BUSY wins
      iframe  = 1'b0;
      request = 4'b1011;
      push_exp(1, 4'b1101, 3'd1, 1'b1, 1'b0);
      repeat (2) step();
      iframe = 1'b1;
      push_exp(1, 4'hF, 3'd1, 1'b0, 1'b0);
      push_exp(3, 4'b1011, 3'd2, 1'b0, 1'b0);
      repeat (3) step();

      // Reset during BUSY
      iframe = 1'b0;
      push_exp(1, 4'b1011, 3'd2, 1'b1, 1'b0);
      repeat (2) step();
      rst = 1'b1;
      repeat (2) step();
      chk_reset("reset_in_busy");
      rst     = 1'b0;
      iframe  = 1'b1;
      request = 4'b1001;
      push_exp(1, 4'b1101, 3'd1, 1'b0, 1'b0);
      step();
      request = 4'hF;
      push_exp(1, 4'hF, 3'd1, 1'b0, 1'b0);
      repeat (2) step();

      // Granted device never starts a transaction
      request = 4'b1100;
      push_exp(1, 4'b1110, 3'd0, 1'b0, 1'b0);
`ifdef PCI_ARB_TIMEOUT_EN
      push_exp(17, 4'hF, 3'd0, 1'b0, 1'b1);
      push_exp(18, 4'b1101, 3'd1, 1'b0, 1'b0);
      repeat (18) step();
      request = 4'hF;
      push_exp(1, 4'hF, 3'd1, 1'b0, 1'b0);
      repeat (3) step();
`else
      repeat (40) step();
      request = 4'hF;
      push_exp(1, 4'hF, 3'd0, 1'b0, 1'b0);
      repeat (3) step();
`endif

      for (int i = 0; i < 20 && q.size() != 0; i++) step();
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL pending_events left=%0d required 0", q.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
